// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: CPU/video arbiter and sequencer for a tri-state RAM address mux bank.
// Define RAM_ARB_GUARD_EN to insert one bus-idle GUARD cycle on every owner change.
module ram_bus_arbiter #(
  parameter int ACCESS_CYC = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic vid_req,
  output logic mux_sel,
  output logic mux_oe_n,
  output logic cpu_ack,
  output logic vid_ack,
  output logic cpu_wait,
  output logic owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT   = 4'(ACCESS_CYC - 1);
  localparam logic [7:0] STARVE_THR = 8'(STARVE_LIM);

  state_t     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic [7:0] starve_r, starve_s;
  logic       mux_sel_r, mux_sel_s;
  logic       mux_oe_n_r, mux_oe_n_s;
  logic       cpu_ack_r, cpu_ack_s;
  logic       vid_ack_r, vid_ack_s;
  logic       owner_r, owner_s;
  logic       win_vld_s, win_s, guard_s, last_s, ack_s;

  // Arbitration: CPU wins when video is quiet or once the CPU has starved long enough.
  always_comb begin
    win_vld_s = 1'b0;
    win_s     = owner_r;
    if (cpu_req && ((starve_r >= STARVE_THR) || !vid_req)) begin
      win_vld_s = 1'b1;
      win_s     = 1'b0;
    end else if (vid_req) begin
      win_vld_s = 1'b1;
      win_s     = 1'b1;
    end else begin
      win_vld_s = 1'b0;
      win_s     = owner_r;
    end
  end

`ifdef RAM_ARB_GUARD_EN
  assign guard_s = win_s ^ owner_r;
`else
  assign guard_s = 1'b0;
`endif

  assign last_s = (state_r == GRANT) && (cnt_r == LAST_CNT);

  // Next-state, access counter and registered bus-control values.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    mux_sel_s  = mux_sel_r;
    owner_s    = owner_r;
    mux_oe_n_s = 1'b1;
    case (state_r)
      IDLE, GRANT: begin
        if ((state_r == GRANT) && !last_s) begin
          state_s    = GRANT;
          cnt_s      = cnt_r + 4'd1;
          mux_oe_n_s = 1'b0;
        end else if (win_vld_s) begin
          // Select and owner move together so the guard cycle already drives the new side.
          owner_s   = win_s;
          mux_sel_s = win_s;
          cnt_s     = 4'd0;
          if (guard_s) begin
            state_s    = GUARD;
            mux_oe_n_s = 1'b1;
          end else begin
            state_s    = GRANT;
            mux_oe_n_s = 1'b0;
          end
        end else begin
          state_s    = IDLE;
          cnt_s      = 4'd0;
          mux_oe_n_s = 1'b1;
        end
      end
      GUARD: begin
        state_s    = GRANT;
        cnt_s      = 4'd0;
        mux_oe_n_s = 1'b0;
      end
      default: begin
        state_s    = IDLE;
        cnt_s      = 4'd0;
        mux_oe_n_s = 1'b1;
      end
    endcase
  end

  assign ack_s     = (state_s == GRANT) && (cnt_s == LAST_CNT);
  assign cpu_ack_s = ack_s & ~owner_s;
  assign vid_ack_s = ack_s & owner_s;

  // Starvation counter: counts CPU waiting cycles, cleared when the CPU is served or idle.
  always_comb begin
    starve_s = starve_r;
    if (!cpu_req) begin
      starve_s = 8'd0;
    end else if ((state_s == GRANT) && !owner_s) begin
      starve_s = 8'd0;
    end else if ((state_r == GRANT) && !owner_r) begin
      starve_s = starve_r;
    end else if (starve_r != 8'hFF) begin
      starve_s = starve_r + 8'd1;
    end else begin
      starve_s = starve_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      starve_r   <= 8'd0;
      mux_sel_r  <= 1'b0;
      mux_oe_n_r <= 1'b1;
      cpu_ack_r  <= 1'b0;
      vid_ack_r  <= 1'b0;
      owner_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      starve_r   <= starve_s;
      mux_sel_r  <= mux_sel_s;
      mux_oe_n_r <= mux_oe_n_s;
      cpu_ack_r  <= cpu_ack_s;
      vid_ack_r  <= vid_ack_s;
      owner_r    <= owner_s;
    end
  end

  assign mux_sel  = mux_sel_r;
  assign mux_oe_n = mux_oe_n_r;
  assign cpu_ack  = cpu_ack_r;
  assign vid_ack  = vid_ack_r;
  assign owner    = owner_r;
  assign cpu_wait = cpu_req & ~cpu_ack_r;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: scoreboard bench for ram_bus_arbiter (ACCESS_CYC=2, STARVE_LIM=8).
// Expectations follow RAM_ARB_GUARD_EN when it is defined for the build.
module tb_ram_bus_arbiter;

  localparam int AC = 2;
  localparam int SL = 8;
`ifdef RAM_ARB_GUARD_EN
  localparam int GD = 1;
`else
  localparam int GD = 0;
`endif

  typedef struct {
    logic who;
    int   cyc;
  } exp_t;

  logic clk, rst_n, cpu_req, vid_req;
  logic mux_sel, mux_oe_n, cpu_ack, vid_ack, cpu_wait, owner;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic vid_hold = 1'b0;
  logic wait_smp = 1'b0;
  logic prev_oe_n = 1'b1;
  logic prev_sel = 1'b0;

  ram_bus_arbiter #(.ACCESS_CYC(AC), .STARVE_LIM(SL)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .vid_req(vid_req),
    .mux_sel(mux_sel), .mux_oe_n(mux_oe_n), .cpu_ack(cpu_ack), .vid_ack(vid_ack),
    .cpu_wait(cpu_wait), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input logic who, input int at);
    exp_t e;
    e.who = who;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  // One clock: sample just after the edge, score acks, then let requesters react.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    wait_smp = cpu_wait;
    if (cpu_ack || vid_ack) begin
      chk_eq("ack_excl", {31'd0, cpu_ack & vid_ack}, 32'd0);
      if (sb_q.size() == 0) begin
        chk_eq("sb_extra", {30'd0, cpu_ack, vid_ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk_eq("sb_who", {31'd0, vid_ack}, {31'd0, e.who});
        chk_eq("sb_cyc", cyc, e.cyc);
      end
    end
`ifdef RAM_ARB_GUARD_EN
    if (!prev_oe_n && !mux_oe_n) chk_eq("sel_stable", {31'd0, mux_sel}, {31'd0, prev_sel});
`endif
    prev_oe_n = mux_oe_n;
    prev_sel  = mux_sel;
    if (cpu_ack) cpu_req = 1'b0;
    if (vid_ack && !vid_hold) vid_req = 1'b0;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk_bus(input string tag, input logic oe_n_e, input logic sel_e, input logic own_e);
    chk_eq({tag, "_oe_n"}, {31'd0, mux_oe_n}, {31'd0, oe_n_e});
    chk_eq({tag, "_sel"}, {31'd0, mux_sel}, {31'd0, sel_e});
    chk_eq({tag, "_owner"}, {31'd0, owner}, {31'd0, own_e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, v, a, p, q1, q2, d, j;
    rst_n   = 1'b0;
    cpu_req = 1'b1;
    vid_req = 1'b1;
    step(); step(); step();
    chk_bus("rst", 1'b1, 1'b0, 1'b0);
    chk_eq("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk_eq("rst_vid_ack", {31'd0, vid_ack}, 32'd0);
    chk_eq("rst_wait", {31'd0, wait_smp}, 32'd1);

    // Release with both requests pending: video first, then CPU.
    c = cyc;
    rst_n = 1'b1;
    push_exp(1'b1, c + GD + AC);
    push_exp(1'b0, c + 2*GD + 2*AC);
    step_to(c + 1);
    chk_bus("a_first", 1'(GD), 1'b1, 1'b1);
    step_to(c + GD + 1);
    chk_bus("a_vgrant", 1'b0, 1'b1, 1'b1);
    step_to(c + GD + AC + 1);
    chk_bus("a_switch", 1'(GD), 1'b0, 1'b0);
    step_to(c + 2*GD + 2*AC + 1);
    chk_bus("a_idle", 1'b1, 1'b0, 1'b0);
    chk_eq("a_wait", {31'd0, wait_smp}, 32'd0);
    chk_eq("a_drain", sb_q.size(), 0);

    // Single CPU access on an idle bus already owned by the CPU.
    step(); step();
    c = cyc;
    cpu_req = 1'b1;
    #1;
    chk_eq("b_wait0", {31'd0, cpu_wait}, 32'd1);
    push_exp(1'b0, c + AC);
    step_to(c + 1);
    chk_bus("b_grant", 1'b0, 1'b0, 1'b0);
    chk_eq("b_wait1", {31'd0, wait_smp}, 32'd1);
    step_to(c + AC);
    chk_eq("b_ack", {31'd0, cpu_ack}, 32'd1);
    chk_eq("b_wait_ack", {31'd0, wait_smp}, 32'd0);
    step_to(c + AC + 1);
    chk_bus("b_idle", 1'b1, 1'b0, 1'b0);
    chk_eq("b_drain", sb_q.size(), 0);

    // Video access, CPU arrives during it: owner handoff.
    step();
    c = cyc;
    vid_req = 1'b1;
    v = c + GD + AC;
    push_exp(1'b1, v);
    push_exp(1'b0, v + GD + AC);
    step_to(c + 1);
    chk_bus("c_vstart", 1'(GD), 1'b1, 1'b1);
    cpu_req = 1'b1;
    step_to(v);
    chk_bus("c_vlast", 1'b0, 1'b1, 1'b1);
    step_to(v + 1);
    chk_bus("c_hand", 1'(GD), 1'b0, 1'b0);
    step_to(v + 1 + GD);
    chk_bus("c_cgrant", 1'b0, 1'b0, 1'b0);
    step_to(v + GD + AC + 1);
    chk_bus("c_idle", 1'b1, 1'b0, 1'b0);
    chk_eq("c_drain", sb_q.size(), 0);

    // Starvation: video held continuously, CPU waits until the limit.
    step();
    c = cyc;
    vid_hold = 1'b1;
    vid_req  = 1'b1;
    cpu_req  = 1'b1;
    j = (SL - GD + AC - 1) / AC;
    a = c + GD + j*AC;
    for (int i = 1; i <= j; i++) push_exp(1'b1, c + GD + i*AC);
    p = a + GD + AC;
    push_exp(1'b0, p);
    for (int k = c + 1 + GD; k <= a; k++) begin
      step_to(k);
      chk_eq("d_b2b_oe", {31'd0, mux_oe_n}, 32'd0);
    end
    step_to(a + 1);
    chk_bus("d_starve", 1'(GD), 1'b0, 1'b0);
    step_to(p + 1);
    chk_bus("d_vback", 1'(GD), 1'b1, 1'b1);
    cpu_req = 1'b1;
    q1 = p + GD + AC;
    q2 = q1 + AC;
    push_exp(1'b1, q1);
    push_exp(1'b1, q2);
    push_exp(1'b0, q2 + GD + AC);
    step_to(q1 + 1);
    chk_bus("d_cleared", 1'b0, 1'b1, 1'b1);
    vid_hold = 1'b0;
    step_to(q2 + 1);
    chk_bus("d_cpu2", 1'(GD), 1'b0, 1'b0);
    step_to(q2 + GD + AC + 1);
    chk_bus("d_idle", 1'b1, 1'b0, 1'b0);
    chk_eq("d_drain", sb_q.size(), 0);

    // Reset during the first cycle of a video grant, then normal recovery.
    step();
    c = cyc;
    vid_req = 1'b1;
    step_to(c + 1 + GD);
    chk_bus("e_grant", 1'b0, 1'b1, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk_bus("e_async", 1'b1, 1'b0, 1'b0);
    chk_eq("e_vid_ack", {31'd0, vid_ack}, 32'd0);
    step(); step(); step();
    chk_bus("e_hold", 1'b1, 1'b0, 1'b0);
    d = cyc;
    rst_n = 1'b1;
    push_exp(1'b1, d + GD + AC);
    step_to(d + 1);
    chk_bus("e_resume", 1'(GD), 1'b1, 1'b1);
    step_to(d + GD + AC + 1);
    chk_bus("e_idle", 1'b1, 1'b1, 1'b1);
    chk_eq("e_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
